// File: rtl/axi_llc_evict_engine.sv
// LLC eviction engine: accepts descriptors, writes dirty lines back over AXI (AW then BeatsPerLine W beats),
// retires descriptors in order after B. Optional B error counter under AXI_LLC_EVICT_ERR_CNT_EN.
module axi_llc_evict_engine #(
   parameter int unsigned AddrWidth    = 64,
   parameter int unsigned DataWidth    = 64,
   parameter int unsigned NumWays      = 8,
   parameter int unsigned BeatsPerLine = 4,
   parameter int unsigned MaxWbTxns    = 4,
   parameter int unsigned QueueDepth   = 8,
   parameter int unsigned IdWidth      = 4,
   parameter int unsigned AwId         = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 desc_valid_i,
   output logic                 desc_ready_o,
   input  logic [AddrWidth-1:0] desc_addr_i,
   input  logic [NumWays-1:0]   desc_way_ind_i,
   input  logic                 desc_evict_i,
   input  logic                 desc_flush_i,
   output logic                 desc_valid_o,
   input  logic                 desc_ready_i,
   output logic [AddrWidth-1:0] desc_addr_o,
   output logic [NumWays-1:0]   desc_way_ind_o,
   output logic                 way_req_valid_o,
   input  logic                 way_req_ready_i,
   output logic [NumWays-1:0]   way_req_ind_o,
   output logic [AddrWidth-1:0] way_req_addr_o,
   output logic [7:0]           way_req_beat_o,
   input  logic                 way_rdata_valid_i,
   input  logic [DataWidth-1:0] way_rdata_i,
   output logic                 way_rdata_ready_o,
   output logic                 aw_valid_o,
   input  logic                 aw_ready_i,
   output logic [AddrWidth-1:0] aw_addr_o,
   output logic [7:0]           aw_len_o,
   output logic [2:0]           aw_size_o,
   output logic [IdWidth-1:0]   aw_id_o,
   output logic                 w_valid_o,
   input  logic                 w_ready_i,
   output logic [DataWidth-1:0] w_data_o,
   output logic                 w_last_o,
   input  logic                 b_valid_i,
   output logic                 b_ready_o,
   input  logic [1:0]           b_resp_i,
   output logic                 flush_desc_recv_o,
   output logic [15:0]          err_cnt_o
);

   localparam int unsigned LineBytes = BeatsPerLine * DataWidth / 8;
   localparam int unsigned PtrW      = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
   localparam int unsigned CntW      = $clog2(QueueDepth + 1);
   localparam int unsigned OutW      = $clog2(MaxWbTxns + 1);

   localparam logic [AddrWidth-1:0] OffMask  = AddrWidth'(LineBytes - 1);
   localparam logic [7:0]           AwLen    = 8'(BeatsPerLine - 1);
   localparam logic [2:0]           AwSize   = 3'($clog2(DataWidth / 8));
   localparam logic [IdWidth-1:0]   AwIdC    = IdWidth'(AwId);
   localparam logic [8:0]           Beats9   = 9'(BeatsPerLine);
   localparam logic [8:0]           LastBeat = 9'(BeatsPerLine - 1);
   localparam logic [PtrW-1:0]      PtrLast  = PtrW'(QueueDepth - 1);
   localparam logic [CntW-1:0]      QDepthC  = CntW'(QueueDepth);
   localparam logic [OutW-1:0]      MaxOutC  = OutW'(MaxWbTxns);

   typedef enum logic [1:0] {IDLE, SEND_AW, STREAM, FWD} state_e;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [NumWays-1:0]   way;
      logic                 flush;
      logic                 needs_b;
      logic                 b_seen;
   } entry_t;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [NumWays-1:0]   way_q, way_d;
   logic                 flush_q, flush_d;
   logic [8:0]           req_cnt_q, req_cnt_d;
   logic [8:0]           dat_cnt_q, dat_cnt_d;
   logic [OutW-1:0]      out_cnt_q, out_cnt_d;

   entry_t               q_mem_q [QueueDepth];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      q_cnt_q, q_cnt_d;

   entry_t head;
   entry_t push_entry;
   logic   head_vld, head_done, push, pop, b_hs, w_last_hs;

   // Retirement side: the queue head decides B acceptance and downstream forwarding.
   assign head      = q_mem_q[rd_ptr_q];
   assign head_vld  = (q_cnt_q != '0);
   assign b_ready_o = head_vld & head.needs_b & ~head.b_seen;
   assign b_hs      = b_valid_i & b_ready_o;
   assign head_done = head_vld & (~head.needs_b | head.b_seen);

   assign desc_valid_o      = head_done & ~head.flush;
   assign flush_desc_recv_o = head_done & head.flush;
   assign desc_addr_o       = desc_valid_o ? head.addr : '0;
   assign desc_way_ind_o    = desc_valid_o ? head.way  : '0;
   assign pop               = flush_desc_recv_o | (desc_valid_o & desc_ready_i);

   assign w_last_hs = (state_q == STREAM) & way_rdata_valid_i & w_ready_i & (dat_cnt_q == LastBeat);
   assign push      = w_last_hs | (state_q == FWD);

   always_comb begin
      push_entry         = '0;
      push_entry.addr    = addr_q;
      push_entry.way     = way_q;
      push_entry.flush   = flush_q;
      push_entry.needs_b = (state_q == STREAM);
   end

   assign aw_addr_o      = (state_q == SEND_AW) ? (addr_q & ~OffMask) : '0;
   assign aw_len_o       = (state_q == SEND_AW) ? AwLen : '0;
   assign aw_size_o      = (state_q == SEND_AW) ? AwSize : '0;
   assign aw_id_o        = (state_q == SEND_AW) ? AwIdC : '0;
   assign way_req_ind_o  = (state_q == STREAM) ? way_q : '0;
   assign way_req_addr_o = (state_q == STREAM) ? addr_q : '0;
   assign way_req_beat_o = (state_q == STREAM) ? req_cnt_q[7:0] : '0;

   always_comb begin
      state_d           = state_q;
      addr_d            = addr_q;
      way_d             = way_q;
      flush_d           = flush_q;
      req_cnt_d         = req_cnt_q;
      dat_cnt_d         = dat_cnt_q;
      desc_ready_o      = 1'b0;
      aw_valid_o        = 1'b0;
      way_req_valid_o   = 1'b0;
      way_rdata_ready_o = 1'b0;
      w_valid_o         = 1'b0;
      w_data_o          = '0;
      w_last_o          = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A queue slot is reserved here, so the burst that follows can always push.
            desc_ready_o = (out_cnt_q < MaxOutC) && (q_cnt_q < QDepthC);
            if (desc_valid_i && desc_ready_o) begin
               addr_d    = desc_addr_i;
               way_d     = desc_way_ind_i;
               flush_d   = desc_flush_i;
               req_cnt_d = '0;
               dat_cnt_d = '0;
               state_d   = desc_evict_i ? SEND_AW : FWD;
            end
         end
         SEND_AW: begin
            aw_valid_o = 1'b1;
            if (aw_ready_i) state_d = STREAM;
         end
         STREAM: begin
            way_req_valid_o = (req_cnt_q < Beats9);
            if (way_req_valid_o && way_req_ready_i) req_cnt_d = req_cnt_q + 9'd1;
            w_valid_o         = way_rdata_valid_i;
            w_data_o          = way_rdata_i;
            way_rdata_ready_o = w_ready_i;
            w_last_o          = (dat_cnt_q == LastBeat);
            if (way_rdata_valid_i && w_ready_i) begin
               dat_cnt_d = dat_cnt_q + 9'd1;
               if (w_last_o) state_d = IDLE;
            end
         end
         FWD: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      unique case ({w_last_hs, b_hs})
         2'b10:   out_cnt_d = out_cnt_q + 1'b1;
         2'b01:   out_cnt_d = out_cnt_q - 1'b1;
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   always_comb begin
      q_cnt_d = q_cnt_q;
      unique case ({push, pop})
         2'b10:   q_cnt_d = q_cnt_q + 1'b1;
         2'b01:   q_cnt_d = q_cnt_q - 1'b1;
         default: q_cnt_d = q_cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         way_q     <= '0;
         flush_q   <= 1'b0;
         req_cnt_q <= '0;
         dat_cnt_q <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         way_q     <= way_d;
         flush_q   <= flush_d;
         req_cnt_q <= req_cnt_d;
         dat_cnt_q <= dat_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(QueueDepth); i++) q_mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         q_cnt_q  <= '0;
      end else begin
         if (push) begin
            q_mem_q[wr_ptr_q] <= push_entry;
            wr_ptr_q          <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
         end
         // A head awaiting B is never retiring, so b_seen and pop cannot collide.
         if (b_hs) q_mem_q[rd_ptr_q].b_seen <= 1'b1;
         if (pop) rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
         q_cnt_q <= q_cnt_d;
      end
   end

`ifdef AXI_LLC_EVICT_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        unused_resp_lsb;

   assign unused_resp_lsb = b_resp_i[0];

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (b_hs && b_resp_i[1] && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_cnt_q <= '0;
      else         err_cnt_q <= err_cnt_d;
   end

   assign err_cnt_o = err_cnt_q;
`else
   logic unused_resp;

   assign unused_resp = ^b_resp_i;
   assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_axi_llc_evict_engine.sv
// Bench for axi_llc_evict_engine: directed scenarios plus randomized descriptors against a queue-based model.
module tb_axi_llc_evict_engine;

   localparam int AWD = 64, DW = 64, NW = 8, BEATS = 4, MAXWB = 4, QD = 8, IDW = 4, AWID = 0;
   localparam longint LINE_BYTES = BEATS * DW / 8;
`ifdef AXI_LLC_EVICT_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk, rst_ni;
   logic desc_valid_i, desc_ready_o, desc_evict_i, desc_flush_i;
   logic [AWD-1:0] desc_addr_i, desc_addr_o, way_req_addr_o, aw_addr_o;
   logic [NW-1:0] desc_way_ind_i, desc_way_ind_o, way_req_ind_o;
   logic desc_valid_o, desc_ready_i, way_req_valid_o, way_req_ready_i;
   logic [7:0] way_req_beat_o, aw_len_o;
   logic way_rdata_valid_i, way_rdata_ready_o, aw_valid_o, aw_ready_i;
   logic [DW-1:0] way_rdata_i, w_data_o;
   logic [2:0] aw_size_o;
   logic [IDW-1:0] aw_id_o;
   logic w_valid_o, w_ready_i, w_last_o, b_valid_i, b_ready_o, flush_desc_recv_o;
   logic [1:0] b_resp_i;
   logic [15:0] err_cnt_o;

   axi_llc_evict_engine #(
      .AddrWidth(AWD), .DataWidth(DW), .NumWays(NW), .BeatsPerLine(BEATS),
      .MaxWbTxns(MAXWB), .QueueDepth(QD), .IdWidth(IDW), .AwId(AWID)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_addr_i(desc_addr_i),
      .desc_way_ind_i(desc_way_ind_i), .desc_evict_i(desc_evict_i), .desc_flush_i(desc_flush_i),
      .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_addr_o(desc_addr_o),
      .desc_way_ind_o(desc_way_ind_o),
      .way_req_valid_o(way_req_valid_o), .way_req_ready_i(way_req_ready_i), .way_req_ind_o(way_req_ind_o),
      .way_req_addr_o(way_req_addr_o), .way_req_beat_o(way_req_beat_o),
      .way_rdata_valid_i(way_rdata_valid_i), .way_rdata_i(way_rdata_i), .way_rdata_ready_o(way_rdata_ready_o),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
      .aw_size_o(aw_size_o), .aw_id_o(aw_id_o),
      .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_last_o(w_last_o),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
      .flush_desc_recv_o(flush_desc_recv_o), .err_cnt_o(err_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line contents as the way array would return them.
   function automatic logic [63:0] line_data(input logic [63:0] a, input logic [7:0] w, input logic [7:0] b);
      return (a * 64'h9E3779B97F4A7C15) ^ {w, 48'h0, b};
   endfunction

   // Observed traffic, written only by the slave process.
   logic [127:0] aw_rec[$], w_rec[$], out_rec[$];
   logic [63:0]  rd_q[$];
   int flush_n = 0, err_seen = 0, pending_b = 0;
   bit rd_hs = 0, b_hs_f = 0;
   // Knobs, written only by the main sequence.
   bit b_en = 1;
   int b_mode = 0;

   initial begin : slave
      way_req_ready_i = 0; way_rdata_valid_i = 0; way_rdata_i = '0; aw_ready_i = 0;
      w_ready_i = 0; b_valid_i = 0; b_resp_i = '0; desc_ready_i = 0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            rd_q.delete(); pending_b = 0; err_seen = 0; rd_hs = 0; b_hs_f = 0;
            way_req_ready_i = 0; way_rdata_valid_i = 0; way_rdata_i = '0; aw_ready_i = 0;
            w_ready_i = 0; b_valid_i = 0; b_resp_i = '0; desc_ready_i = 0;
         end else begin
            if (rd_hs) begin void'(rd_q.pop_front()); way_rdata_valid_i = 0; rd_hs = 0; end
            if (b_hs_f) begin b_valid_i = 0; b_hs_f = 0; end
            way_req_ready_i = ($urandom_range(0, 3) != 0);
            aw_ready_i      = ($urandom_range(0, 2) != 0);
            w_ready_i       = ($urandom_range(0, 3) != 0);
            desc_ready_i    = ($urandom_range(0, 2) != 0);
            if (!way_rdata_valid_i && rd_q.size() > 0 && $urandom_range(0, 3) != 0) begin
               way_rdata_valid_i = 1; way_rdata_i = rd_q[0];
            end
            if (!b_valid_i && b_en && pending_b > 0 && $urandom_range(0, 2) != 0) begin
               b_valid_i = 1;
               b_resp_i  = (b_mode == 0) ? 2'b00 : (b_mode == 1) ? 2'b10 : 2'($urandom_range(0, 3));
            end
            #1;
            if (way_req_valid_o && way_req_ready_i)
               rd_q.push_back(line_data(way_req_addr_o, way_req_ind_o, way_req_beat_o));
            if (way_rdata_valid_i && way_rdata_ready_o) rd_hs = 1;
            if (aw_valid_o && aw_ready_i) aw_rec.push_back({49'b0, aw_id_o, aw_size_o, aw_len_o, aw_addr_o});
            if (w_valid_o && w_ready_i) begin
               w_rec.push_back({63'b0, w_last_o, w_data_o});
               if (w_last_o) pending_b++;
            end
            if (b_valid_i && b_ready_o) begin
               b_hs_f = 1; pending_b--;
               if (b_resp_i[1]) err_seen++;
            end
            if (desc_valid_o && desc_ready_i) out_rec.push_back({56'b0, desc_way_ind_o, desc_addr_o});
            if (flush_desc_recv_o) flush_n++;
         end
      end
   end

   // Reference model: what each accepted descriptor must produce, in acceptance order.
   logic [127:0] exp_aw[$], exp_w[$], exp_out[$];
   int exp_flush = 0;
   int aw_base = 0, w_base = 0, out_base = 0, flush_base = 0;

   task automatic model_add(input logic [63:0] a, input logic [7:0] w, input logic ev, input logic fl);
      logic [63:0] line_addr;
      if (ev) begin
         line_addr = 64'(a - (a % LINE_BYTES));
         exp_aw.push_back({49'b0, 4'(AWID), 3'd3, 8'(BEATS - 1), line_addr});
         for (int b = 0; b < BEATS; b++)
            exp_w.push_back({63'b0, (b == BEATS - 1), line_data(a, w, 8'(b))});
      end
      if (fl) exp_flush++;
      else    exp_out.push_back({56'b0, w, a});
   endtask

   task automatic send(input logic [63:0] a, input logic [7:0] w, input logic ev, input logic fl);
      bit ok = 0;
      @(negedge clk);
      desc_valid_i = 1; desc_addr_i = a; desc_way_ind_i = w; desc_evict_i = ev; desc_flush_i = fl;
      for (int t = 0; t < 400; t++) begin
         #1;
         if (desc_ready_o) begin ok = 1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      desc_valid_i = 0;
      chk("desc_accept", ok, 1);
      if (ok) model_add(a, w, ev, fl);
   endtask

   task automatic rebase();
      aw_base = aw_rec.size(); w_base = w_rec.size(); out_base = out_rec.size(); flush_base = flush_n;
      exp_aw.delete(); exp_w.delete(); exp_out.delete(); exp_flush = 0;
   endtask

   task automatic check_all(input string tag);
      bit done = 0;
      for (int t = 0; t < 4000 && !done; t++) begin
         @(negedge clk);
         done = (aw_rec.size() - aw_base == exp_aw.size()) && (w_rec.size() - w_base == exp_w.size()) &&
                (out_rec.size() - out_base == exp_out.size()) && (flush_n - flush_base == exp_flush) &&
                (pending_b == 0);
      end
      chk({tag, "_drain"}, done, 1);
      repeat (5) @(negedge clk);
      chk({tag, "_aw_n"}, aw_rec.size() - aw_base, exp_aw.size());
      chk({tag, "_w_n"}, w_rec.size() - w_base, exp_w.size());
      chk({tag, "_out_n"}, out_rec.size() - out_base, exp_out.size());
      chk({tag, "_flush_n"}, flush_n - flush_base, exp_flush);
      for (int i = 0; i < exp_aw.size(); i++)
         if (aw_base + i < aw_rec.size()) chk($sformatf("%s_aw%0d", tag, i), aw_rec[aw_base + i], exp_aw[i]);
      for (int i = 0; i < exp_w.size(); i++)
         if (w_base + i < w_rec.size()) chk($sformatf("%s_w%0d", tag, i), w_rec[w_base + i], exp_w[i]);
      for (int i = 0; i < exp_out.size(); i++)
         if (out_base + i < out_rec.size()) chk($sformatf("%s_out%0d", tag, i), out_rec[out_base + i], exp_out[i]);
      chk({tag, "_err"}, err_cnt_o, ERR_EN ? err_seen : 0);
      rebase();
   endtask

   initial begin : main
      bit seen;
      int n;
      rst_ni = 0; desc_valid_i = 0; desc_addr_i = '0; desc_way_ind_i = '0; desc_evict_i = 0; desc_flush_i = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valids", {aw_valid_o, w_valid_o, way_req_valid_o, desc_valid_o, b_ready_o,
                         flush_desc_recv_o, way_rdata_ready_o}, 0);
      chk("rst_err", err_cnt_o, 0);
      chk("rst_data", {aw_addr_o, desc_addr_o}, 0);
      chk("rst_len", {aw_len_o, aw_size_o, w_last_o}, 0);
      @(negedge clk); rst_ni = 1;
      @(negedge clk); #1;
      chk("idle_ready", desc_ready_o, 1);

      // Single dirty line.
      send(64'h1038, 8'h04, 1, 0);
      check_all("single");
      n = aw_rec.size();
      chk("single_awaddr", aw_rec[n - 1][63:0], 64'h1020);
      chk("single_awlen", aw_rec[n - 1][71:64], 8'd3);
      n = out_rec.size();
      chk("single_out", out_rec[n - 1][63:0], 64'h1038);

      // Clean descriptor queued behind an evict waits for its B.
      b_en = 0;
      send(64'h5000, 8'h02, 1, 0);
      send(64'h6010, 8'h20, 0, 0);
      repeat (40) @(negedge clk);
      chk("order_hold", out_rec.size() - out_base, 0);
      b_en = 1;
      check_all("order");

      // Outstanding write-back limit.
      b_en = 0;
      for (int i = 0; i < 4; i++) send(64'h10000 + 64'(i) * 64'h40, 8'h01 << i, 1, 0);
      for (int t = 0; t < 2000 && (w_rec.size() - w_base < 16); t++) @(negedge clk);
      @(negedge clk); #1;
      chk("limit_aw4", aw_rec.size() - aw_base, 4);
      chk("limit_rdy0", desc_ready_o, 0);
      @(negedge clk);
      desc_valid_i = 1; desc_addr_i = 64'h10100; desc_way_ind_i = 8'h10; desc_evict_i = 1; desc_flush_i = 0;
      seen = 0;
      repeat (30) begin @(negedge clk); #1; if (desc_ready_o) seen = 1; end
      chk("limit_block", seen, 0);
      chk("limit_aw_still4", aw_rec.size() - aw_base, 4);
      b_en = 1;
      send(64'h10100, 8'h10, 1, 0);
      check_all("limit");

      // Flush with write-back, and a clean flush.
      send(64'h2000, 8'h01, 1, 1);
      check_all("flush_ev");
      send(64'h2200, 8'h08, 0, 1);
      check_all("flush_clean");

      // Error responses.
      b_mode = 1;
      send(64'h7000, 8'h40, 1, 0);
      send(64'h7040, 8'h80, 1, 0);
      check_all("err");
      chk("err_two", err_cnt_o, ERR_EN ? 16'd2 : 16'd0);

      // Random mix.
      b_mode = 2;
      for (int i = 0; i < 40; i++)
         send({$urandom, $urandom}, 8'h01 << $urandom_range(0, 7),
              $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
      check_all("rnd");

      // Reset in the middle of a burst.
      b_mode = 0;
      send(64'h3040, 8'h10, 1, 0);
      for (int t = 0; t < 2000 && (w_rec.size() - w_base < 2); t++) @(negedge clk);
      chk("mid_two_beats", w_rec.size() - w_base, 2);
      rst_ni = 0;
      #1;
      chk("mid_rst_valids", {aw_valid_o, w_valid_o, way_req_valid_o, desc_valid_o, b_ready_o,
                             flush_desc_recv_o, way_rdata_ready_o}, 0);
      chk("mid_rst_err", err_cnt_o, 0);
      repeat (3) @(negedge clk);
      rst_ni = 1;
      rebase();
      repeat (20) @(negedge clk);
      chk("mid_no_aw", aw_rec.size() - aw_base, 0);
      chk("mid_no_w", w_rec.size() - w_base, 0);
      chk("mid_no_out", out_rec.size() - out_base, 0);
      send(64'h4008, 8'h80, 1, 0);
      check_all("mid_fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
